// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: sequential MIPS instruction fetcher with a small in-order
// instruction queue. It issues one word request at a time, queues the
// returned words together with their word address, and restarts the fetch
// stream on branch, jump and jump-register redirects.
module mips_fetch_queue #(
  parameter int                ADDR_W   = 30,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W+1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redir_valid,
  input  logic [1:0]        redir_kind,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [31:0]       busa,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  output logic              addr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_JR     = 2'b10;
  localparam logic [1:0] KIND_NONE   = 2'b11;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              outstanding;
  logic              discard;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              redir_take;
  logic              grant;
  logic              push;
  logic              pop;
  logic              queue_empty;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] target;

  assign redir_take  = redir_valid && (redir_kind != KIND_NONE);
  assign queue_empty = (count == '0);

  // Only one request in flight; the queue slot for it is reserved up front,
  // so a returning word always has room. Redirect cycles never request.
  assign imem_req  = reset && !outstanding && (count < CNT_W'(DEPTH)) && !redir_take;
  assign imem_addr = {pc, 2'b00};
  assign grant     = imem_req && imem_gnt;

  // Responses belonging to a stream abandoned by a redirect are dropped.
  assign push = imem_rvalid && outstanding && !discard && !redir_take;
  assign pop  = !queue_empty && ir_ready && !redir_take;

  assign ir_valid = !queue_empty;
  assign ir       = queue_empty ? '0 : data_mem[rd_ptr];
  assign ir_pc    = queue_empty ? '0 : pc_mem[rd_ptr];

  // Redirect target selection; kind 11 never reaches the pc because
  // redir_take is low for it.
  always_comb begin
    seq_pc = redir_pc + ADDR_W'(1);
    target = seq_pc + {{(ADDR_W-16){imm16[15]}}, imm16};
    case (redir_kind)
      KIND_BRANCH: target = seq_pc + {{(ADDR_W-16){imm16[15]}}, imm16};
      KIND_JUMP:   target = {seq_pc[ADDR_W-1:26], imm26};
      KIND_JR:     target = busa[ADDR_W+1:2];
      default:     target = seq_pc;
    endcase
  end

  // Fetch pc, outstanding/discard tracking and the misaligned-JR pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= redir_take && (redir_kind == KIND_JR) && (busa[1:0] != 2'b00);

      if (redir_take) begin
        pc <= target;
      end else if (grant) begin
        pc     <= pc + ADDR_W'(1);
        req_pc <= pc;
      end

      if (imem_rvalid) begin
        outstanding <= 1'b0;
      end else if (grant) begin
        outstanding <= 1'b1;
      end

      // A response that arrives in the redirect cycle is already consumed,
      // so only a still-pending one has to be discarded later.
      if (redir_take) begin
        discard <= outstanding && !imem_rvalid;
      end else if (imem_rvalid) begin
        discard <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redir_take) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Queue storage: instruction word and the word address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb_mips_fetch_queue: randomized fetch-queue bench. The driver plays the
// instruction memory, the consumer and the redirect source; a monitor checks
// the fetch address stream and the popped instruction stream against a
// stream-level model (a redirect restarts both streams at its target).
module tb_mips_fetch_queue;

  localparam int          ADDR_W = 30;
  localparam int unsigned MASK   = 32'h3FFF_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W+1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redir_valid;
  logic [1:0]        redir_kind;
  logic [ADDR_W-1:0] redir_pc;
  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [31:0]       busa;
  logic              ir_valid;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              addr_err;

  mips_fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_pc(redir_pc),
    .imm16(imm16), .imm26(imm26), .busa(busa),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int unsigned pend_q[$];   // granted word addresses awaiting a response
  int unsigned tgt_q[$];    // expected restart address per accepted redirect

  // staged inputs, applied by step() just after the next rising edge
  logic        n_reset = 1'b0;
  logic        n_gnt   = 1'b0;
  logic        n_ready = 1'b0;
  logic        hold_rv = 1'b0;
  int          rv_pct  = 100;
  logic        r_valid = 1'b0;
  logic [1:0]  r_kind  = 2'b11;
  int unsigned r_pc    = 0;
  logic [15:0] r_i16   = '0;
  logic [25:0] r_i26   = '0;
  logic [31:0] r_busa  = '0;
  int          n_grants = 0;

  function automatic logic [31:0] memfn(int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int unsigned target_of(logic [1:0] k, int unsigned rpc,
                                            logic [15:0] i16, logic [25:0] i26,
                                            logic [31:0] ba);
    int          off;
    int unsigned nxt;
    off = int'($signed(i16));
    nxt = (rpc + 32'd1) & MASK;
    case (k)
      2'b00:   return (rpc + 32'd1 + 32'(off)) & MASK;
      2'b01:   return ((nxt >> 26) << 26) | 32'(i26);
      default: return (ba >> 2) & MASK;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stage_redir(logic [1:0] k, int unsigned rpc, logic [15:0] i16,
                             logic [25:0] i26, logic [31:0] ba);
    r_valid = 1'b1;
    r_kind  = k;
    r_pc    = rpc & MASK;
    r_i16   = i16;
    r_i26   = i26;
    r_busa  = ba;
  endtask

  // One clock: drive at posedge+2, then capture grants at the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
    reset = n_reset;
    if (n_reset && !hold_rv && pend_q.size() != 0 && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt    = n_gnt;
    ir_ready    = n_ready;
    redir_valid = r_valid;
    redir_kind  = r_kind;
    redir_pc    = r_pc[ADDR_W-1:0];
    imm16       = r_i16;
    imm26       = r_i26;
    busa        = r_busa;
    if (r_valid && r_kind != 2'b11)
      tgt_q.push_back(target_of(r_kind, r_pc, r_i16, r_i26, r_busa));
    r_valid = 1'b0;
    r_kind  = 2'($urandom);
    r_pc    = $urandom & MASK;
    r_i16   = 16'($urandom);
    r_i26   = 26'($urandom);
    r_busa  = $urandom;
    @(negedge clk);
    if (!reset) begin
      pend_q.delete();
    end else if (imem_req && imem_gnt) begin
      pend_q.push_back(32'(imem_addr >> 2));
      n_grants++;
    end
  endtask

  // Monitor: reset values, fetch addresses, popped instructions, addr_err.
  initial begin : monitor
    int unsigned exp_fetch;
    int unsigned exp_pop;
    logic        err_due;
    exp_fetch = 0;
    exp_pop   = 0;
    err_due   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_fetch = 0;
        exp_pop   = 0;
        err_due   = 1'b0;
        tgt_q.delete();
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_ir_valid", 64'(ir_valid), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
      end else begin
        check("addr_err", 64'(addr_err), 64'(err_due));
        err_due = redir_valid && redir_kind == 2'b10 && busa[1:0] != 2'b00;
        if (redir_valid && redir_kind != 2'b11) begin
          check("req_in_redirect", 64'(imem_req), 64'd0);
          if (tgt_q.size() == 0) begin
            check("redirect_target_known", 64'd0, 64'd1);
          end else begin
            exp_fetch = tgt_q.pop_front();
            exp_pop   = exp_fetch;
          end
        end else begin
          if (imem_req && imem_gnt) begin
            check("fetch_addr", 64'(imem_addr), 64'(exp_fetch << 2));
            exp_fetch = (exp_fetch + 1) & MASK;
          end
          if (ir_valid && ir_ready) begin
            check("pop_pc", 64'(ir_pc), 64'(exp_pop));
            check("pop_ir", 64'(ir), 64'(memfn(exp_pop)));
            exp_pop = (exp_pop + 1) & MASK;
          end
        end
        if (!ir_valid) check("empty_head", {2'b00, ir_pc, ir}, 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redir_valid = 1'b0;
    redir_kind  = 2'b11;
    redir_pc    = '0;
    imm16       = '0;
    imm26       = '0;
    busa        = '0;
    ir_ready    = 1'b0;
    #1 reset    = 1'b0;

    // Fill: grant tied high, one-cycle response, consumer stalled.
    n_reset = 1'b0;
    n_gnt   = 1'b1;
    n_ready = 1'b0;
    rv_pct  = 100;
    repeat (3) step();
    n_reset  = 1'b1;
    n_grants = 0;
    repeat (12) step();
    check("fill_grants", 64'(n_grants), 64'd4);
    check("fill_req_off", 64'(imem_req), 64'd0);
    check("fill_head_valid", 64'(ir_valid), 64'd1);
    check("fill_head_pc", 64'(ir_pc), 64'd0);
    check("fill_head_ir", 64'(ir), 64'(memfn(0)));

    // Backward branch from a full queue.
    n_gnt = 1'b0;
    stage_redir(2'b00, 32'h10, 16'hFFFE, 26'($urandom), $urandom);
    step();
    step();
    check("branch_req", 64'(imem_req), 64'd1);
    check("branch_addr", 64'(imem_addr), 64'h3C);
    check("branch_flushed", 64'(ir_valid), 64'd0);

    // Jump while a request is outstanding: the late response is dropped.
    n_gnt   = 1'b1;
    hold_rv = 1'b1;
    for (int k = 0; k < 10 && pend_q.size() == 0; k++) step();
    check("jump_pending", 64'(pend_q.size()), 64'd1);
    stage_redir(2'b01, 32'h03FF_FFFF, 16'($urandom), 26'h000_0004, $urandom);
    step();
    hold_rv = 1'b0;
    step();
    step();
    check("stale_dropped", 64'(ir_valid), 64'd0);
    check("jump_addr", 64'(imem_addr), 64'h1000_0010);
    step();
    step();
    check("jump_head_valid", 64'(ir_valid), 64'd1);
    check("jump_head_pc", 64'(ir_pc), 64'h400_0004);

    // Misaligned jump-register, then an ignored kind 11.
    n_ready = 1'b1;
    stage_redir(2'b10, $urandom, 16'($urandom), 26'($urandom), 32'h0000_0102);
    step();
    step();
    check("jr_addr_err", 64'(addr_err), 64'd1);
    stage_redir(2'b11, $urandom, 16'($urandom), 26'($urandom), 32'h0000_0003);
    step();
    check("jr_err_pulse_len", 64'(addr_err), 64'd0);

    // Streaming with simultaneous push and pop.
    n_gnt   = 1'b1;
    n_ready = 1'b1;
    rv_pct  = 100;
    repeat (60) step();

    // Randomized traffic with one mid-run reset.
    begin
      int rdy_pct;
      rdy_pct = 50;
      for (int i = 0; i < 4000; i++) begin
        if (i % 500 == 0) begin
          rv_pct  = 30 + int'($urandom_range(70));
          rdy_pct = int'($urandom_range(100));
        end
        if (i == 2000) begin
          n_reset = 1'b0;
          repeat (2) step();
          n_reset = 1'b1;
        end
        n_gnt   = ($urandom_range(3) != 0);
        n_ready = ($urandom_range(99) < rdy_pct);
        if ($urandom_range(24) == 0) begin
          logic [31:0] ba;
          ba = $urandom;
          if ($urandom_range(1) == 0) ba[1:0] = 2'b00;
          stage_redir(2'($urandom), $urandom, 16'($urandom), 26'($urandom), ba);
        end
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
